// File: rtl/fwrisc_exec_formal_stim_driver.sv
// Decode-side stimulus driver for the fwrisc exec unit: issues LFSR-derived
// ALU instructions one at a time and scores each register write-back.
module fwrisc_exec_formal_stim_driver #(
    parameter int unsigned NUM_INSTR       = 16,
    parameter int unsigned TIMEOUT         = 15,
    parameter logic [31:0] LFSR_SEED       = 32'h0000_0001,
    parameter logic [4:0]  OP_TYPE_ARITH_V = 5'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    output logic        decode_valid,
    output logic        instr_c,
    output logic [4:0]  op_type,
    output logic [5:0]  op,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] op_c,
    input  logic        instr_complete,
    input  logic        rd_wen,
    input  logic [5:0]  rd_waddr,
    input  logic [31:0] rd_wdata,
    output logic [7:0]  issued_count,
    output logic        done,
    output logic        pass,
    output logic        err_timeout,
    output logic        err_mismatch,
    output logic        err_spurious
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [2:0]  opcnt_q, opcnt_d;
    logic [7:0]  issued_q, issued_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        cap_q, cap_d;
    logic [5:0]  cap_addr_q, cap_addr_d;
    logic [31:0] cap_data_q, cap_data_d;
    logic [31:0] exp_q, exp_d;
    logic        decode_valid_q, decode_valid_d;
    logic [4:0]  op_type_q, op_type_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] op_c_q, op_c_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        err_t_q, err_t_d;
    logic        err_m_q, err_m_d;
    logic        err_s_q, err_s_d;

    logic [31:0] lfsr_next;
    logic [31:0] alu_res;
    logic        wr_seen;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mm_now;

    always_comb begin
        lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : '0);
        case (op_q)
            6'd0:    alu_res = op_a_q + op_b_q;
            6'd1:    alu_res = op_a_q - op_b_q;
            6'd2:    alu_res = op_a_q & op_b_q;
            6'd3:    alu_res = op_a_q | op_b_q;
            6'd4:    alu_res = op_a_q ^ op_b_q;
            default: alu_res = '0;
        endcase
        // A write in the completion cycle counts as the instruction's write
        wr_seen = cap_q | rd_wen;
        wr_addr = cap_q ? cap_addr_q : rd_waddr;
        wr_data = cap_q ? cap_data_q : rd_wdata;
        mm_now  = !wr_seen || (wr_addr != op_c_q[5:0]) || (wr_data != exp_q) || (cap_q && rd_wen);
    end

    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        opcnt_d        = opcnt_q;
        issued_d       = issued_q;
        wait_cnt_d     = wait_cnt_q;
        cap_d          = cap_q;
        cap_addr_d     = cap_addr_q;
        cap_data_d     = cap_data_q;
        exp_d          = exp_q;
        decode_valid_d = 1'b0;
        op_type_d      = '0;
        op_d           = op_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_c_d         = op_c_q;
        done_d         = done_q;
        pass_d         = pass_q;
        err_t_d        = err_t_q;
        err_m_d        = err_m_q;
        err_s_d        = err_s_q;

        case (state_q)
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (instr_complete) begin
                    err_m_d = err_m_q | mm_now;
                    lfsr_d  = lfsr_next;
                    opcnt_d = (opcnt_q == 3'd4) ? 3'd0 : opcnt_q + 3'd1;
                    // An error takes precedence over reaching the instruction count
                    if (err_m_d || err_t_q || err_s_q) begin
                        state_d = S_ERROR;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                    end else if (issued_q == 8'(NUM_INSTR)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (rd_wen) begin
                        if (cap_q) begin
                            err_m_d = 1'b1;
                        end else begin
                            cap_d      = 1'b1;
                            cap_addr_d = rd_waddr;
                            cap_data_d = rd_wdata;
                        end
                    end
                    // Flag lands on the TIMEOUT-th edge after the issue cycle
                    if (wait_cnt_d == 8'(TIMEOUT - 1)) begin
                        err_t_d = 1'b1;
                        state_d = S_ERROR;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                    end
                end
            end
            default: begin
                if (instr_complete || rd_wen) begin
                    err_s_d = 1'b1;
                    state_d = S_ERROR;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (state_q == S_IDLE && en) begin
                    state_d        = S_ISSUE;
                    decode_valid_d = 1'b1;
                    op_type_d      = OP_TYPE_ARITH_V;
                    op_a_d         = lfsr_q;
                    op_b_d         = {lfsr_q[15:0], lfsr_q[31:16]} ^ 32'h5A5A_5A5A;
                    op_d           = {3'b000, opcnt_q};
                    op_c_d         = {26'b0, 1'b0, issued_q[4:0] | 5'd1};
                end else if (state_q == S_ISSUE) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                    issued_d   = issued_q + 8'd1;
                    exp_d      = alu_res;
                    cap_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            lfsr_q         <= LFSR_SEED;
            opcnt_q        <= '0;
            issued_q       <= '0;
            wait_cnt_q     <= '0;
            cap_q          <= 1'b0;
            cap_addr_q     <= '0;
            cap_data_q     <= '0;
            exp_q          <= '0;
            decode_valid_q <= 1'b0;
            op_type_q      <= '0;
            op_q           <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_c_q         <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_t_q        <= 1'b0;
            err_m_q        <= 1'b0;
            err_s_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            opcnt_q        <= opcnt_d;
            issued_q       <= issued_d;
            wait_cnt_q     <= wait_cnt_d;
            cap_q          <= cap_d;
            cap_addr_q     <= cap_addr_d;
            cap_data_q     <= cap_data_d;
            exp_q          <= exp_d;
            decode_valid_q <= decode_valid_d;
            op_type_q      <= op_type_d;
            op_q           <= op_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_c_q         <= op_c_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            err_t_q        <= err_t_d;
            err_m_q        <= err_m_d;
            err_s_q        <= err_s_d;
        end
    end

    assign decode_valid = decode_valid_q;
    assign instr_c      = 1'b0;
    assign op_type      = op_type_q;
    assign op           = op_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_c         = op_c_q;
    assign issued_count = issued_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_timeout  = err_t_q;
    assign err_mismatch = err_m_q;
    assign err_spurious = err_s_q;

endmodule

// File: tb/tb_fwrisc_exec_formal_stim_driver.sv
// Directed bench for fwrisc_exec_formal_stim_driver: a small exec model answers
// each issue, and immediate assertions compare outputs with hand-derived values.
module tb_fwrisc_exec_formal_stim_driver;

    logic        clock;
    logic        reset;
    logic        en;
    logic        decode_valid;
    logic        instr_c;
    logic [4:0]  op_type;
    logic [5:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
    logic        instr_complete;
    logic        rd_wen;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic [7:0]  issued_count;
    logic        done;
    logic        pass;
    logic        err_timeout;
    logic        err_mismatch;
    logic        err_spurious;

    int unsigned n_cmp;
    int unsigned n_err;

    fwrisc_exec_formal_stim_driver #(
        .NUM_INSTR      (16),
        .TIMEOUT        (15),
        .LFSR_SEED      (32'h0000_0001),
        .OP_TYPE_ARITH_V(5'd0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .decode_valid  (decode_valid),
        .instr_c       (instr_c),
        .op_type       (op_type),
        .op            (op),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_c          (op_c),
        .instr_complete(instr_complete),
        .rd_wen        (rd_wen),
        .rd_waddr      (rd_waddr),
        .rd_wdata      (rd_wdata),
        .issued_count  (issued_count),
        .done          (done),
        .pass          (pass),
        .err_timeout   (err_timeout),
        .err_mismatch  (err_mismatch),
        .err_spurious  (err_spurious)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        en             = 1'b0;
        instr_complete = 1'b0;
        rd_wen         = 1'b0;
        rd_waddr       = '0;
        rd_wdata       = '0;
        reset          = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Returns at the negedge of the issue cycle; a missing issue is a failure
    task automatic wait_issue(input string tag);
        int unsigned budget;
        budget = 0;
        @(negedge clock);
        while (decode_valid !== 1'b1 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        if (decode_valid !== 1'b1) check({tag, "_issue_seen"}, {31'b0, decode_valid}, 32'd1);
    endtask

    // Exec model: completion plus write-back three cycles after the issue cycle
    task automatic respond(input logic [5:0] addr, input logic [31:0] data);
        repeat (3) @(negedge clock);
        instr_complete = 1'b1;
        rd_wen         = 1'b1;
        rd_waddr       = addr;
        rd_wdata       = data;
        @(negedge clock);
        instr_complete = 1'b0;
        rd_wen         = 1'b0;
    endtask

    function automatic logic [31:0] alu(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    logic [31:0] m_lfsr, m_a, m_b, m_res;
    logic [2:0]  m_op;
    int unsigned reissue;

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset state and full 16-instruction run with correct write-backs
        apply_reset();
        @(negedge clock);
        check("rst_decode_valid", {31'b0, decode_valid}, 32'd0);
        check("rst_issued", {24'b0, issued_count}, 32'd0);
        check("rst_done_pass", {30'b0, done, pass}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_errs", {29'b0, err_timeout, err_mismatch, err_spurious}, 32'd0);

        en     = 1'b1;
        m_lfsr = 32'h0000_0001;
        m_op   = 3'd0;
        for (int i = 0; i < 16; i++) begin
            wait_issue("run");
            m_a   = m_lfsr;
            m_b   = {m_a[15:0], m_a[31:16]} ^ 32'h5A5A_5A5A;
            m_res = alu(m_op, m_a, m_b);
            if (i == 0) begin
                check("first_op_a", op_a, 32'h0000_0001);
                check("first_op_b", op_b, 32'h5A5B_5A5A);
                check("first_op", {26'b0, op}, 32'd0);
                check("first_op_c", op_c, 32'd1);
                check("first_instr_c_type", {26'b0, instr_c, op_type}, 32'd0);
                @(negedge clock);
                check("strobe_one_cycle", {31'b0, decode_valid}, 32'd0);
                check("issued_after_1", {24'b0, issued_count}, 32'd1);
                repeat (2) @(negedge clock);
                instr_complete = 1'b1;
                rd_wen         = 1'b1;
                rd_waddr       = 6'd1;
                rd_wdata       = 32'h5A5B_5A5B;
                @(negedge clock);
                instr_complete = 1'b0;
                rd_wen         = 1'b0;
            end else begin
                check("run_op_a", op_a, m_a);
                check("run_op_b", op_b, m_b);
                check("run_op", {26'b0, op}, {29'b0, m_op});
                check("run_op_c", op_c, {27'b0, 5'(i) | 5'd1});
                respond(6'(5'(i) | 5'd1), m_res);
            end
            m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
            m_op   = (m_op == 3'd4) ? 3'd0 : m_op + 3'd1;
        end
        repeat (2) @(negedge clock);
        check("run_done", {31'b0, done}, 32'd1);
        check("run_pass", {31'b0, pass}, 32'd1);
        check("run_issued", {24'b0, issued_count}, 32'd16);
        check("run_errs", {29'b0, err_timeout, err_mismatch, err_spurious}, 32'd0);

        // Wrong write data on the first instruction
        apply_reset();
        en = 1'b1;
        wait_issue("bad_data");
        respond(6'd1, 32'h5A5B_5A5C);
        repeat (2) @(negedge clock);
        check("bad_data_mismatch", {31'b0, err_mismatch}, 32'd1);
        check("bad_data_done_pass", {30'b0, done, pass}, 32'd2);
        check("bad_data_issued", {24'b0, issued_count}, 32'd1);
        reissue = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (decode_valid === 1'b1) reissue++;
        end
        check("bad_data_halted", reissue, 32'd0);

        // Exec never completes
        apply_reset();
        en = 1'b1;
        wait_issue("timeout");
        repeat (14) @(negedge clock);
        check("timeout_not_yet", {31'b0, err_timeout}, 32'd0);
        @(negedge clock);
        check("timeout_at_15", {31'b0, err_timeout}, 32'd1);
        reissue = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (decode_valid === 1'b1) reissue++;
        end
        check("timeout_no_reissue", reissue, 32'd0);
        check("timeout_done_pass", {30'b0, done, pass}, 32'd2);

        // Completion pulse while idle
        apply_reset();
        repeat (2) @(negedge clock);
        instr_complete = 1'b1;
        @(negedge clock);
        instr_complete = 1'b0;
        repeat (2) @(negedge clock);
        check("spurious_flag", {31'b0, err_spurious}, 32'd1);
        check("spurious_done_pass", {30'b0, done, pass}, 32'd2);
        check("spurious_issued", {24'b0, issued_count}, 32'd0);

        // Correct data to the wrong register
        apply_reset();
        en = 1'b1;
        wait_issue("bad_addr");
        respond(6'd2, 32'h5A5B_5A5B);
        repeat (2) @(negedge clock);
        check("bad_addr_mismatch", {31'b0, err_mismatch}, 32'd1);
        check("bad_addr_pass", {31'b0, pass}, 32'd0);

        // Reset mid-WAIT aborts cleanly and restarts from the seed
        apply_reset();
        en = 1'b1;
        wait_issue("mid_rst");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_issued", {24'b0, issued_count}, 32'd0);
        check("mid_rst_op_a", op_a, 32'd0);
        check("mid_rst_errs", {27'b0, done, pass, err_timeout, err_mismatch, err_spurious}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        wait_issue("after_rst");
        check("after_rst_op_a", op_a, 32'h0000_0001);
        check("after_rst_op_b", op_b, 32'h5A5B_5A5A);
        check("after_rst_issued", {24'b0, issued_count}, 32'd0);
        check("after_rst_errs", {27'b0, done, pass, err_timeout, err_mismatch, err_spurious}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
